uart_receiver: RTL
==================

Name: uart_receiver

Overview:
Receive side of the team's UART link. Deserialises frames produced by uart_transmitter: 1 start bit (0), 8 data bits LSB first, 1 even-parity bit (XOR of the 8 data bits), 1 stop bit (1). Uses 16x oversampling from a baud-select-driven tick generator and delivers each byte with a one-cycle valid strobe plus parity/framing error flags. Sits between the RxD pad and the consuming logic; the clk domain is 50 MHz.

Parameters:
OVERSAMPLE, 16, sample ticks per bit period; the mid-bit sample point is OVERSAMPLE/2.
SYNC_STAGES, 2, flip-flop stages on RxD before any logic uses it.

Ports:
clk  input  1  system clock, 50 MHz.
reset  input  1  asynchronous, active-low reset.
baud_select  input  3  rate select: 0=300, 1=1200, 2=4800, 3=9600, 4=19200, 5=38400, 6=57600, 7=115200 baud.
Rx_EN  input  1  receiver enable; low forces IDLE.
RxD  input  1  serial line, idle high, asynchronous to clk.
Rx_DATA  output  8  last received byte.
Rx_VALID  output  1  one-clk strobe: Rx_DATA, Rx_PERROR and Rx_FERROR are updated.
Rx_PERROR  output  1  parity mismatch on the last frame.
Rx_FERROR  output  1  stop bit sampled 0 on the last frame.

Behaviour:
- Clock and reset: clk is the clock; reset is asynchronous, active-low. While in reset: Rx_DATA=0x00, Rx_VALID=0, Rx_PERROR=0, Rx_FERROR=0, FSM=IDLE, tick counter=0, sample counter=0, synchroniser flops=1.
- Tick generator: free-running counter on clk. It pulses tick for 1 clk every DIV[baud_select] clks, counting 0..DIV-1.
  - DIV table: 10417, 2604, 651, 326, 163, 81, 54, 27.
  - A change of baud_select takes effect at the next counter wrap.
- RxD passes through SYNC_STAGES flops. All logic uses the synchronised rxd_s.
- FSM states: IDLE, START, DATA, PARITY, STOP. The sample counter scnt (4 bits) advances only on tick.
  - IDLE: Rx_EN=1 and rxd_s=0 -> START, scnt=0, error flags cleared.
  - START: at scnt=7 (mid-bit), rxd_s=0 -> DATA with scnt=0 and bit index=0. rxd_s=1 is a glitch -> IDLE, no strobe, flags remain cleared.
  - DATA: at scnt=7, shift rxd_s into shift register bit [index], LSB first. At scnt=15 increment index. After index 7 completes -> PARITY.
  - PARITY: at scnt=7, Rx_PERROR <= rxd_s XOR (XOR of shift register). Then -> STOP after scnt=15.
  - STOP: at scnt=7, Rx_FERROR <= ~rxd_s and Rx_DATA <= shift register. Rx_VALID=1 on the next clk for exactly 1 clk. FSM -> IDLE immediately, with no wait for the remaining half bit, so back-to-back frames are caught.
- Latency: Rx_VALID rises 1 clk after the stop-bit mid-sample tick, about 10.5 bit periods after the start-bit falling edge plus SYNC_STAGES clks.
- Rx_DATA and both error flags hold their values until the next Rx_VALID. A frame with errors still updates Rx_DATA and still strobes Rx_VALID.
- Framing error with RxD still low: FSM returns to IDLE but does not restart until rxd_s has been 1 for at least one tick (a break condition does not retrigger).
- Rx_EN deasserted mid-frame: abort to IDLE on the next clk. No strobe; outputs are left unchanged.
- Reset mid-frame: asynchronous abort to the reset values.
- Simultaneous events: Rx_EN low has priority over a start detect.

Decomposition:
- Package uart_pkg holds:
  - the DIV table, as a function baud_div(sel) returning 14 bits;
  - FSM state localparams: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4;
  - frame constants: DATA_BITS=8, STOP_LEVEL=1.
  - uart_transmitter is expected to migrate to this package later.
- One sub-module, uart_sample_tick(clk, reset, baud_select, tick), holds the divider counter.

Test Plan:
1. baud_select=7 (432 clks/bit); send 0xA5 with parity 0 and stop 1 -> Rx_VALID 1-clk pulse, Rx_DATA=0xA5, PERROR=0, FERROR=0, latency 4538±16 clks from start edge.
2. baud_select=7; send 0x01 with parity bit 0 (wrong) -> Rx_DATA=0x01, Rx_PERROR=1, Rx_FERROR=0.
3. Send 0x3C (parity 0) with stop bit 0 -> Rx_FERROR=1; hold RxD low 2 further bit times -> no second Rx_VALID.
4. Low glitch of 100 clks on idle RxD -> no Rx_VALID, FSM back in IDLE; then send 0xFF (parity 0) -> Rx_DATA=0xFF.
5. Back-to-back frames 0x55 then 0xAA, with no idle gap after the stop bit, at baud_select=3 -> two strobes carrying the correct bytes and clean flags.
6. Mid-frame checks:
   - drop Rx_EN after 4 data bits -> no strobe, Rx_DATA unchanged;
   - assert reset mid-frame -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: baud divider table, receiver states, frame constants.
package uart_pkg;

    localparam int   DATA_BITS  = 8;
    localparam logic STOP_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    // clk cycles per oversample tick at 50 MHz, 16 ticks per bit
    function automatic logic [13:0] baud_div(input logic [2:0] sel);
        logic [13:0] d;
        case (sel)
            3'd0:    d = 14'd10417;
            3'd1:    d = 14'd2604;
            3'd2:    d = 14'd651;
            3'd3:    d = 14'd326;
            3'd4:    d = 14'd163;
            3'd5:    d = 14'd81;
            3'd6:    d = 14'd54;
            default: d = 14'd27;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/uart_sample_tick.sv
// Oversample tick generator: one-clk pulse every baud_div(baud_select) clks.
module uart_sample_tick
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    output logic       tick
);

    logic [13:0] cnt;
    logic [13:0] lim;

    assign tick = (cnt == lim);

    // the limit is reloaded only on wrap so a rate change never cuts a period short
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            lim <= '0;
        end else if (tick) begin
            cnt <= '0;
            lim <= baud_div(baud_select) - 14'd1;
        end else begin
            cnt <= cnt + 14'd1;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// UART receive path: 8 data bits LSB first, even parity, 1 stop bit,
// 16x oversampled, one-clk valid strobe with parity/framing flags.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    input  logic       Rx_EN,
    input  logic       RxD,
    output logic [7:0] Rx_DATA,
    output logic       Rx_VALID,
    output logic       Rx_PERROR,
    output logic       Rx_FERROR
);

    localparam int             SW  = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0]  MID = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [2:0]     LAST_BIT = 3'(DATA_BITS - 1);

    logic                   tick;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxd_s;

    rx_state_t     state, state_n;
    logic [SW-1:0] scnt, scnt_n;
    logic [2:0]    bidx, bidx_n;
    logic [7:0]    shreg, shreg_n;
    logic          perr_q, perr_n;
    logic          ferr_q, ferr_n;
    logic          armed, armed_n;
    logic [7:0]    data_n;
    logic          valid_n;
    logic          pout_n;
    logic          fout_n;

    uart_sample_tick u_tick (
        .clk         (clk),
        .reset       (reset),
        .baud_select (baud_select),
        .tick        (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], RxD};
        end
    end

    assign rxd_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            scnt      <= '0;
            bidx      <= '0;
            shreg     <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            armed     <= 1'b1;
            Rx_DATA   <= '0;
            Rx_VALID  <= 1'b0;
            Rx_PERROR <= 1'b0;
            Rx_FERROR <= 1'b0;
        end else begin
            state     <= state_n;
            scnt      <= scnt_n;
            bidx      <= bidx_n;
            shreg     <= shreg_n;
            perr_q    <= perr_n;
            ferr_q    <= ferr_n;
            armed     <= armed_n;
            Rx_DATA   <= data_n;
            Rx_VALID  <= valid_n;
            Rx_PERROR <= pout_n;
            Rx_FERROR <= fout_n;
        end
    end

    // scnt keeps running through the frame, so every scnt==MID after the
    // start-bit check lands one full bit later, at the next mid-bit point
    always_comb begin
        state_n = state;
        scnt_n  = scnt;
        bidx_n  = bidx;
        shreg_n = shreg;
        perr_n  = perr_q;
        ferr_n  = ferr_q;
        armed_n = armed;
        data_n  = Rx_DATA;
        valid_n = 1'b0;
        pout_n  = Rx_PERROR;
        fout_n  = Rx_FERROR;

        if (tick && rxd_s) begin
            armed_n = 1'b1;
        end

        if (!Rx_EN) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!rxd_s && armed) begin
                        state_n = START;
                        scnt_n  = '0;
                        bidx_n  = '0;
                        perr_n  = 1'b0;
                        ferr_n  = 1'b0;
                    end
                end
                START: begin
                    if (tick) begin
                        scnt_n = scnt + 1'b1;
                        if (scnt == MID) begin
                            state_n = rxd_s ? IDLE : DATA;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        scnt_n = scnt + 1'b1;
                        if (scnt == MID) begin
                            shreg_n[bidx] = rxd_s;
                            bidx_n        = bidx + 3'd1;
                            if (bidx == LAST_BIT) begin
                                state_n = PARITY;
                            end
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        scnt_n = scnt + 1'b1;
                        if (scnt == MID) begin
                            perr_n  = rxd_s ^ (^shreg);
                            state_n = STOP;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        scnt_n = scnt + 1'b1;
                        if (scnt == MID) begin
                            ferr_n  = (rxd_s != STOP_LEVEL);
                            data_n  = shreg;
                            pout_n  = perr_q;
                            fout_n  = (rxd_s != STOP_LEVEL);
                            valid_n = 1'b1;
                            state_n = IDLE;
                            if (!rxd_s) begin
                                armed_n = 1'b0;
                            end
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule
